// File: rtl/sdram_pattern_tester_pkg.sv
// Shared types for the SDRAM pattern tester: pattern modes, FSM states and
// maximal-length Galois LFSR tap masks (right-shifting form, bit k = tap k+1).
package sdram_test_pkg;

    typedef enum logic [1:0] {
        PAT_INC  = 2'd0,
        PAT_WALK = 2'd1,
        PAT_LFSR = 2'd2,
        PAT_INV  = 2'd3
    } pattern_mode_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WR_ISSUE,
        ST_WR_GAP,
        ST_RD_ISSUE,
        ST_RD_WAIT,
        ST_DONE
    } state_t;

    function automatic logic [31:0] lfsr_taps(input int unsigned width);
        case (width)
            8:       return 32'h0000_00B8;
            9:       return 32'h0000_0110;
            10:      return 32'h0000_0240;
            11:      return 32'h0000_0500;
            12:      return 32'h0000_0829;
            13:      return 32'h0000_100D;
            14:      return 32'h0000_2015;
            15:      return 32'h0000_6000;
            16:      return 32'h0000_B400;
            24:      return 32'h00E1_0000;
            32:      return 32'h8020_0003;
            default: return 32'h0000_B400;
        endcase
    endfunction

endpackage

// File: rtl/sdram_pattern_tester_if.sv
// Host-side request/response bundle between the pattern tester and the SDRAM
// controller; master issues one-cycle write/read strobes, slave answers with rd_ready.
interface sdram_host_if #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 16
);
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic              wr_enable;
    logic [ADDR_W-1:0] rd_addr;
    logic              rd_enable;
    logic [DATA_W-1:0] rd_data;
    logic              rd_ready;
    logic              busy;

    modport master (
        output wr_addr, wr_data, wr_enable, rd_addr, rd_enable,
        input  rd_data, rd_ready, busy
    );

    modport slave (
        input  wr_addr, wr_data, wr_enable, rd_addr, rd_enable,
        output rd_data, rd_ready, busy
    );
endinterface

// File: rtl/sdram_pattern_gen.sv
// Expected-word generator: combinational for index/address patterns, registered LFSR
// that holds the seed after restart and steps once per advance.
module sdram_pattern_gen
    import sdram_test_pkg::*;
#(
    parameter int unsigned ADDR_W    = 32,
    parameter int unsigned DATA_W    = 16,
    parameter int unsigned IDX_W     = 8,
    parameter logic [31:0] LFSR_SEED = 32'hACE1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              restart,
    input  logic              advance,
    input  pattern_mode_t     mode,
    input  logic [IDX_W-1:0]  index,
    input  logic [ADDR_W-1:0] addr,
    output logic [DATA_W-1:0] word
);
    localparam logic [DATA_W-1:0] SEED = DATA_W'(LFSR_SEED);
    localparam logic [DATA_W-1:0] TAPS = DATA_W'(lfsr_taps(DATA_W));

    logic [DATA_W-1:0] r_lfsr;
    logic [DATA_W-1:0] w_walk;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_lfsr <= SEED;
        end else if (restart) begin
            r_lfsr <= SEED;
        end else if (advance) begin
            r_lfsr <= r_lfsr[0] ? ((r_lfsr >> 1) ^ TAPS) : (r_lfsr >> 1);
        end
    end

    assign w_walk = DATA_W'(1) << (32'(index) % DATA_W);

    always_comb begin
        word = '0;
        case (mode)
            PAT_INC:  word = DATA_W'(index);
            PAT_WALK: word = w_walk;
            PAT_LFSR: word = r_lfsr;
            PAT_INV:  word = ~DATA_W'(addr);
            default:  word = '0;
        endcase
    end

endmodule

// File: rtl/sdram_pattern_tester.sv
// Writes WORDS pattern words, reads them back and counts mismatches/timeouts; at least
// 2 cycles per write, requests held off while busy. Optional: SDRAM_TESTER_ERR_INJECT_EN.
module sdram_pattern_tester
    import sdram_test_pkg::*;
#(
    parameter int unsigned       ADDR_W     = 32,
    parameter int unsigned       DATA_W     = 16,
    parameter int unsigned       WORDS      = 256,
    parameter logic [ADDR_W-1:0] BASE_ADDR  = '0,
    parameter logic [ADDR_W-1:0] STRIDE     = 1,
    parameter logic [31:0]       LFSR_SEED  = 32'hACE1,
    parameter int unsigned       RD_TIMEOUT = 1024
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [1:0]        mode,
`ifdef SDRAM_TESTER_ERR_INJECT_EN
    input  logic              inject,
`endif
    output logic              done,
    output logic              pass,
    output logic [15:0]       err_count,
    output logic [ADDR_W-1:0] first_err_addr,
    sdram_host_if.master      host
);
    localparam int unsigned       IDX_W    = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam int unsigned       TMR_W    = $clog2(RD_TIMEOUT + 1);
    localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(WORDS - 1);
    localparam logic [TMR_W-1:0]  TMR_LAST = TMR_W'(RD_TIMEOUT - 1);

    state_t            r_state, w_next;
    pattern_mode_t     r_mode;
    logic [IDX_W-1:0]  r_idx;
    logic [ADDR_W-1:0] r_addr, r_first, r_wr_addr, r_rd_addr;
    logic [DATA_W-1:0] r_wr_data, w_exp, w_inj;
    logic [TMR_W-1:0]  r_timer;
    logic [15:0]       r_err;
    logic              r_wr_en, r_rd_en;
    logic              w_start_run, w_issue_wr, w_issue_rd, w_wr_next, w_rd_next, w_err, w_last;

    assign w_last = (r_idx == LAST_IDX);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= ST_IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next      = r_state;
        w_start_run = 1'b0;
        w_issue_wr  = 1'b0;
        w_issue_rd  = 1'b0;
        w_wr_next   = 1'b0;
        w_rd_next   = 1'b0;
        w_err       = 1'b0;
        case (r_state)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    w_start_run = 1'b1;
                    w_next      = ST_WR_ISSUE;
                end
            end
            ST_WR_ISSUE: begin
                if (!host.busy) begin
                    w_issue_wr = 1'b1;
                    w_next     = ST_WR_GAP;
                end
            end
            // The strobe is visible during this cycle; busy is re-sampled only after it.
            ST_WR_GAP: begin
                w_wr_next = 1'b1;
                w_next    = w_last ? ST_RD_ISSUE : ST_WR_ISSUE;
            end
            ST_RD_ISSUE: begin
                if (!host.busy) begin
                    w_issue_rd = 1'b1;
                    w_next     = ST_RD_WAIT;
                end
            end
            ST_RD_WAIT: begin
                if (host.rd_ready) begin
                    w_rd_next = 1'b1;
                    w_err     = (host.rd_data != w_exp);
                end else if (r_timer == TMR_LAST) begin
                    w_rd_next = 1'b1;
                    w_err     = 1'b1;
                end
                if (w_rd_next) w_next = w_last ? ST_DONE : ST_RD_ISSUE;
            end
            default: w_next = ST_IDLE;
        endcase
    end

    sdram_pattern_gen #(
        .ADDR_W    (ADDR_W),
        .DATA_W    (DATA_W),
        .IDX_W     (IDX_W),
        .LFSR_SEED (LFSR_SEED)
    ) u_gen (
        .clk     (clk),
        .rst_n   (rst_n),
        .restart (w_start_run | (w_wr_next & w_last)),
        .advance ((w_wr_next | w_rd_next) & ~w_last),
        .mode    (r_mode),
        .index   (r_idx),
        .addr    (r_addr),
        .word    (w_exp)
    );

`ifdef SDRAM_TESTER_ERR_INJECT_EN
    logic r_inject;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)           r_inject <= 1'b0;
        else if (w_start_run) r_inject <= inject;
    end
    assign w_inj = {{(DATA_W-1){1'b0}}, r_inject & (r_idx == '0)};
`else
    assign w_inj = '0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mode    <= PAT_INC;
            r_idx     <= '0;
            r_addr    <= '0;
            r_timer   <= '0;
            r_err     <= '0;
            r_first   <= '0;
            r_wr_en   <= 1'b0;
            r_rd_en   <= 1'b0;
            r_wr_addr <= '0;
            r_wr_data <= '0;
            r_rd_addr <= '0;
        end else begin
            r_wr_en <= w_issue_wr;
            r_rd_en <= w_issue_rd;
            if (w_start_run) begin
                r_mode  <= pattern_mode_t'(mode);
                r_idx   <= '0;
                r_addr  <= BASE_ADDR;
                r_err   <= '0;
                r_first <= '0;
            end
            if (w_issue_wr) begin
                r_wr_addr <= r_addr;
                r_wr_data <= w_exp ^ w_inj;
            end
            if (w_issue_rd) begin
                r_rd_addr <= r_addr;
                r_timer   <= '0;
            end else if (r_state == ST_RD_WAIT) begin
                r_timer <= r_timer + 1'b1;
            end
            // Both phases walk the same index/address sequence from the base.
            if (w_wr_next || w_rd_next) begin
                r_idx  <= w_last ? '0 : r_idx + 1'b1;
                r_addr <= w_last ? BASE_ADDR : r_addr + STRIDE;
            end
            if (w_err) begin
                if (r_err != 16'hFFFF) r_err <= r_err + 16'd1;
                if (r_err == 16'd0)    r_first <= r_addr;
            end
        end
    end

    assign done           = (r_state == ST_DONE);
    assign pass           = done && (r_err == 16'd0);
    assign err_count      = r_err;
    assign first_err_addr = r_first;
    assign host.wr_enable = r_wr_en;
    assign host.wr_addr   = r_wr_addr;
    assign host.wr_data   = r_wr_data;
    assign host.rd_enable = r_rd_en;
    assign host.rd_addr   = r_rd_addr;

endmodule

// File: tb/tb_sdram_pattern_tester.sv
// Bench for sdram_pattern_tester: memory-backed controller model with random busy and
// read latency, fault hooks (corrupt/drop a read), per-scenario checking tasks.
module tb_sdram_pattern_tester;
    localparam int          AW   = 32;
    localparam int          DW   = 16;
    localparam int          NW   = 20;
    localparam int          TMO  = 16;
    localparam logic [31:0] BASE = 32'h0;
    localparam logic [31:0] STR  = 32'h1;
    localparam logic [31:0] NONE = 32'hFFFF_FFFF;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic [1:0]    mode = 2'd0;
    logic          done, pass;
    logic [15:0]   err_count;
    logic [AW-1:0] first_err_addr;
`ifdef SDRAM_TESTER_ERR_INJECT_EN
    logic          inject = 1'b0;
`endif

    sdram_host_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

    sdram_pattern_tester #(
        .ADDR_W(AW), .DATA_W(DW), .WORDS(NW), .BASE_ADDR(BASE), .STRIDE(STR),
        .LFSR_SEED(32'hACE1), .RD_TIMEOUT(TMO)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .mode(mode),
`ifdef SDRAM_TESTER_ERR_INJECT_EN
        .inject(inject),
`endif
        .done(done), .pass(pass), .err_count(err_count),
        .first_err_addr(first_err_addr), .host(bus)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_fail = 0;

    // Controller model state
    logic [15:0] mem [logic [31:0]];
    logic [31:0] wq_addr [$];
    logic [15:0] wq_data [$];
    int          wr_cnt = 0, rd_cnt = 0;
    logic        busy_force = 1'b0, busy_rand = 1'b0;
    logic [31:0] corrupt_addr = NONE, drop_addr = NONE;
    int          spur_req = 0, spur_done = 0;
    logic        pending = 1'b0;
    int          pend_cnt = 0;
    logic [31:0] pend_addr = '0;

    always @(negedge clk) begin
        bus.rd_ready = 1'b0;
        if (!rst_n) begin
            pending     = 1'b0;
            bus.busy    = 1'b0;
            bus.rd_data = '0;
        end else begin
            if (bus.wr_enable) begin
                mem[bus.wr_addr] = bus.wr_data;
                wq_addr.push_back(bus.wr_addr);
                wq_data.push_back(bus.wr_data);
                wr_cnt++;
            end
            if (pending) begin
                pend_cnt--;
                if (pend_cnt == 0) begin
                    pending = 1'b0;
                    if (pend_addr != drop_addr) begin
                        bus.rd_ready = 1'b1;
                        bus.rd_data  = mem.exists(pend_addr) ? mem[pend_addr] : 16'h0000;
                        if (pend_addr == corrupt_addr) bus.rd_data = bus.rd_data ^ 16'h0100;
                    end
                end
            end
            if (bus.rd_enable) begin
                rd_cnt++;
                pending   = 1'b1;
                pend_addr = bus.rd_addr;
                pend_cnt  = $urandom_range(1, 3);
            end else if (spur_req != spur_done && !pending) begin
                bus.rd_ready = 1'b1;
                bus.rd_data  = 16'($urandom);
                spur_done    = spur_req;
            end
            bus.busy = busy_force || (busy_rand && ($urandom_range(0, 3) == 0));
        end
    end

    function automatic logic [15:0] exp_word(input logic [1:0] m, input int i);
        logic [31:0] a;
        logic [15:0] l;
        a = BASE + 32'(i) * STR;
        l = 16'hACE1;
        case (m)
            2'd0: return 16'(i);
            2'd1: return 16'h0001 << (i % 16);
            2'd2: begin
                for (int k = 0; k < i; k++) l = l[0] ? ((l >> 1) ^ 16'hB400) : (l >> 1);
                return l;
            end
            default: return ~a[15:0];
        endcase
    endfunction

    task automatic start_run(input logic [1:0] m);
        @(negedge clk);
        mode  = m;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n_chk++;
        if (done !== 1'b0 || err_count !== 16'd0 || first_err_addr !== 32'd0) begin
            n_fail++;
            $display("FAIL start_clears: done=%b err=%0d first=%h, required 0/0/0", done, err_count, first_err_addr);
        end
    endtask

    task automatic wait_done(input string name);
        int n = 0;
        while (done !== 1'b1 && n < 3000) begin
            @(negedge clk);
            n++;
        end
        n_chk++;
        if (done !== 1'b1) begin
            n_fail++;
            $display("FAIL %s_done: done=%b, required 1 within 3000 cycles", name, done);
        end
    endtask

    task automatic check_writes(input string name, input logic [1:0] m, input int wb, input int rb);
        n_chk++;
        if (wq_addr.size() - wb != NW || rd_cnt - rb != NW) begin
            n_fail++;
            $display("FAIL %s_counts: writes=%0d reads=%0d, required %0d each", name, wq_addr.size() - wb, rd_cnt - rb, NW);
        end
        for (int i = 0; i < NW && wb + i < wq_addr.size(); i++) begin
            n_chk++;
            if (wq_addr[wb+i] !== BASE + 32'(i) * STR || wq_data[wb+i] !== exp_word(m, i)) begin
                n_fail++;
                $display("FAIL %s_word%0d: addr=%h data=%h, required addr=%h data=%h", name, i,
                         wq_addr[wb+i], wq_data[wb+i], BASE + 32'(i) * STR, exp_word(m, i));
            end
        end
    endtask

    task automatic check_result(input string name, input int e_err, input logic [31:0] e_first);
        n_chk++;
        if (err_count !== 16'(e_err) || first_err_addr !== e_first || pass !== (e_err == 0)) begin
            n_fail++;
            $display("FAIL %s_result: err=%0d first=%h pass=%b, required err=%0d first=%h pass=%b",
                     name, err_count, first_err_addr, pass, e_err, e_first, e_err == 0);
        end
    endtask

    task automatic run_mode(input string name, input logic [1:0] m, input int e_err, input logic [31:0] e_first);
        int wb, rb;
        wb = wq_addr.size();
        rb = rd_cnt;
        start_run(m);
        wait_done(name);
        check_writes(name, m, wb, rb);
        check_result(name, e_err, e_first);
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        n_chk++;
        if (done !== 1'b0 || pass !== 1'b0 || err_count !== 16'd0 || first_err_addr !== 32'd0 ||
            bus.wr_enable !== 1'b0 || bus.rd_enable !== 1'b0 || bus.wr_addr !== 32'd0 ||
            bus.wr_data !== 16'd0 || bus.rd_addr !== 32'd0) begin
            n_fail++;
            $display("FAIL reset_values: done=%b pass=%b err=%0d first=%h we=%b re=%b wa=%h wd=%h ra=%h, required all 0",
                     done, pass, err_count, first_err_addr, bus.wr_enable, bus.rd_enable, bus.wr_addr, bus.wr_data, bus.rd_addr);
        end
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_increment();
        int wb, rb;
        busy_rand = 1'b1;
        wb = wq_addr.size();
        rb = rd_cnt;
        start_run(2'd0);
        repeat (6) @(negedge clk);
        mode  = 2'd1;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done("incr");
        check_writes("incr", 2'd0, wb, rb);
        check_result("incr", 0, 32'd0);
    endtask

    task automatic test_walking();
        int wb;
        wb = wq_addr.size();
        run_mode("walk", 2'd1, 0, 32'd0);
        n_chk++;
        if (wq_data.size() < wb + NW || wq_data[wb+16] !== 16'h0001 || wq_data[wb+17] !== 16'h0002) begin
            n_fail++;
            $display("FAIL walk_wrap: word16/17 not 0001/0002 (queue size %0d)", wq_data.size() - wb);
        end
    endtask

    task automatic test_corrupt();
        logic [15:0] e0;
        corrupt_addr = BASE + 32'd5 * STR;
        run_mode("corrupt", 2'($urandom_range(0, 3)), 1, BASE + 32'd5 * STR);
        corrupt_addr = NONE;
        e0 = err_count;
        spur_req++;
        repeat (4) @(negedge clk);
        n_chk++;
        if (err_count !== e0 || done !== 1'b1) begin
            n_fail++;
            $display("FAIL spurious_ready: err=%0d done=%b, required err=%0d done=1", err_count, done, e0);
        end
    endtask

    task automatic test_timeout();
        drop_addr = BASE + 32'd2 * STR;
        run_mode("timeout", 2'($urandom_range(0, 3)), 1, BASE + 32'd2 * STR);
        drop_addr = NONE;
    endtask

    task automatic test_busy_reset();
        int w0, n, seen, c0;
        busy_rand = 1'b0;
        w0 = wr_cnt;
        start_run(2'($urandom_range(0, 3)));
        n = 0;
        while (wr_cnt - w0 < 5 && n < 200) begin @(negedge clk); n++; end
        busy_force = 1'b1;
        repeat (3) @(negedge clk);
        seen = 0;
        for (int k = 0; k < 47; k++) begin
            @(negedge clk);
            if (bus.wr_enable || bus.rd_enable) seen++;
        end
        n_chk++;
        if (seen != 0 || wr_cnt - w0 < 5) begin
            n_fail++;
            $display("FAIL busy_hold: enables seen=%0d writes before hold=%0d, required 0 and >=5", seen, wr_cnt - w0);
        end
        busy_force = 1'b0;
        n = 0;
        while (bus.rd_enable !== 1'b1 && n < 500) begin @(negedge clk); n++; end
        n_chk++;
        if (bus.rd_enable !== 1'b1) begin
            n_fail++;
            $display("FAIL busy_release: rd_enable=%b, required 1 within 500 cycles", bus.rd_enable);
        end
        rst_n = 1'b0;
        #1;
        n_chk++;
        if (bus.wr_enable !== 1'b0 || bus.rd_enable !== 1'b0 || done !== 1'b0 || pass !== 1'b0 ||
            err_count !== 16'd0 || first_err_addr !== 32'd0 || bus.wr_addr !== 32'd0 ||
            bus.wr_data !== 16'd0 || bus.rd_addr !== 32'd0) begin
            n_fail++;
            $display("FAIL async_reset: we=%b re=%b done=%b wa=%h wd=%h ra=%h, required all 0",
                     bus.wr_enable, bus.rd_enable, done, bus.wr_addr, bus.wr_data, bus.rd_addr);
        end
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        c0 = wr_cnt + rd_cnt;
        repeat (10) @(negedge clk);
        n_chk++;
        if (wr_cnt + rd_cnt != c0 || done !== 1'b0) begin
            n_fail++;
            $display("FAIL idle_after_reset: requests=%0d done=%b, required 0 and 0", wr_cnt + rd_cnt - c0, done);
        end
        busy_rand = 1'b1;
    endtask

`ifdef SDRAM_TESTER_ERR_INJECT_EN
    task automatic test_inject();
        int wb, rb;
        logic [1:0] m;
        m = 2'($urandom_range(0, 3));
        wb = wq_addr.size();
        rb = rd_cnt;
        inject = 1'b1;
        start_run(m);
        inject = 1'b0;
        wait_done("inject");
        check_result("inject", 1, BASE);
        n_chk++;
        if (wq_data.size() <= wb || wq_data[wb] !== (exp_word(m, 0) ^ 16'h0001)) begin
            n_fail++;
            $display("FAIL inject_word0: data=%h, required %h", wq_data.size() > wb ? wq_data[wb] : 16'hxxxx,
                     exp_word(m, 0) ^ 16'h0001);
        end
        n_chk++;
        if (rd_cnt - rb != NW) begin
            n_fail++;
            $display("FAIL inject_reads: reads=%0d, required %0d", rd_cnt - rb, NW);
        end
    endtask
`endif

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_increment();
        test_walking();
        test_corrupt();
        test_timeout();
        test_busy_reset();
        run_mode("lfsr", 2'd2, 0, 32'd0);
        run_mode("invaddr", 2'd3, 0, 32'd0);
`ifdef SDRAM_TESTER_ERR_INJECT_EN
        test_inject();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/sdram_pattern_tester.md
# sdram_pattern_tester

Parametrised SDRAM traffic generator and checker that drives the `sdram_controller` host port. It writes a configurable block of words with a selectable data pattern, reads the block back and compares every word. It reports pass/fail, an error count and the first failing address. It replaces the fixed single-word stimulus and runs unchanged in simulation and on hardware.

## Interface
- `ADDR_W`, 32, host address width
- `DATA_W`, 16, host data width (≥ 8)
- `WORDS`, 256, words per run (≥ 1)
- `BASE_ADDR`, 0, first address
- `STRIDE`, 1, address increment per word
- `LFSR_SEED`, 16'hACE1, LFSR seed (low DATA_W bits, non-zero)
- `RD_TIMEOUT`, 1024, max cycles from `rd_enable` to `rd_ready`

Ports:
- `clk`  in  1  single clock; all logic on rising edge
- `rst_n`  in  1  asynchronous, active-low reset
- `start`  in  1  one-cycle pulse; begins a run
- `mode`  in  2  0 = increment, 1 = walking one, 2 = LFSR, 3 = inverted address; sampled on `start`
- `done`  out  1  high from end of run until next `start`
- `pass`  out  1  valid while `done`; 1 iff `err_count == 0`
- `err_count`  out  16  mismatches plus timeouts, saturating at 16'hFFFF
- `first_err_addr`  out  ADDR_W  address of first error; 0 if none
- `wr_addr`/`wr_data`/`wr_enable`  out  ADDR_W/DATA_W/1  controller write request
- `rd_addr`/`rd_enable`  out  ADDR_W/1  controller read request
- `rd_data`  in  DATA_W  controller read data
- `rd_ready`  in  1  read data valid, one cycle
- `busy`  in  1  controller cannot accept a request

## Operation
- Word index i = 0..WORDS-1. addr(i) = BASE_ADDR + i·STRIDE, truncated to ADDR_W.
- Patterns:
  - increment: i[DATA_W-1:0]
  - walking one: 1 << (i mod DATA_W)
  - LFSR: Galois, maximal-length taps for DATA_W. Holds the seed at i = 0 and steps once per word. Reseeded at the start of each phase.
  - inverted address: ~addr(i)[DATA_W-1:0]
- States: IDLE → WR_ISSUE → WR_GAP → (next word, or RD_ISSUE after last word) → RD_WAIT → (next word, or DONE after last word). DONE → WR_ISSUE on `start`.
- WR_ISSUE: when `busy` = 0, drive addr/data with `wr_enable` = 1 for exactly one cycle, then go to WR_GAP.
- WR_GAP: wait one cycle before sampling `busy` again. This tolerates a controller that raises `busy` one cycle late.
- RD_ISSUE: when `busy` = 0, pulse `rd_enable` for one cycle and go to RD_WAIT.
- RD_WAIT:
  - On `rd_ready`, compare `rd_data` with the expected value.
  - If no `rd_ready` arrives within RD_TIMEOUT cycles, count one error and advance.
- Each error increments `err_count`, saturating. The first error captures `first_err_addr`.
- `start` while not in IDLE or DONE is ignored.
- On `start`: clear `done`, `err_count` and `first_err_addr`; latch `mode`; i = 0.
- `rd_ready` outside RD_WAIT is ignored. It is not counted as an error.

## Timing
- Reset values:
  - `wr_enable`, `rd_enable`, `done`, `pass` = 0
  - `err_count` = 0, `first_err_addr` = 0
  - `wr_addr`, `wr_data`, `rd_addr` = 0
  - state IDLE
- Reset asserted mid-run drops both enables immediately (asynchronous). No partial request is held.
- Minimum write cost is 2 cycles per word with `busy` low throughout.
- `done` rises the cycle after the last compare or timeout. `pass` is valid in that same cycle.
- Addresses and data are stable only during the enable cycle. Outside it they hold their last value.
- Address arithmetic wraps modulo 2^ADDR_W with no error.

## Configuration
- `SDRAM_TESTER_ERR_INJECT_EN`:
  - Defined: adds input `inject` (1 bit), sampled on `start`. When it is set, word 0 is written with bit 0 inverted, so the run must end with `err_count` = 1 and `first_err_addr` = BASE_ADDR.
  - Undefined: the port and logic are absent.

## Structure
- Package `sdram_test_pkg` holds:
  - `pattern_mode_t` enum
  - state enum
  - LFSR tap constant function indexed by width
- Sub-module `sdram_pattern_gen` takes (clk, rst_n, restart, advance, mode, index, addr) and produces the expected word. The same instance serves the write phase and the read phase, restarted at the start of each.

## Test plan
- WORDS = 4, mode increment, ideal controller model → writes 0,1,2,3 to addr 0..3; `done` = 1, `pass` = 1, `err_count` = 0.
- Mode walking one, DATA_W = 16, WORDS = 20 → word 16 = 16'h0001, word 17 = 16'h0002; pass.
- Model corrupts the read at addr 5 (XOR 16'h0100), WORDS = 8 → `err_count` = 1, `first_err_addr` = 5, `pass` = 0.
- `rd_ready` suppressed for addr 2, RD_TIMEOUT = 16 → timeout counted, run completes, `err_count` = 1, `first_err_addr` = 2.
- `busy` held high 50 cycles mid-write, then `rst_n` pulsed during the read phase → no enable pulses while busy; enables drop at reset; outputs return to reset values.
- With `SDRAM_TESTER_ERR_INJECT_EN`, `inject` = 1, BASE_ADDR = 32'h100 → `err_count` = 1, `first_err_addr` = 32'h100.
